// File: rtl/letc_core_imss.sv
// Instruction memory subsystem: direct-mapped read-only I-cache with line refill over a backing port.
// Optional hit/miss perf counters are built when LETC_IMSS_PERF_COUNTERS_EN is defined.
module letc_core_imss #(
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_virtual_addr,
  output logic        rsp_valid,
  output logic        rsp_illegal,
  output logic [31:0] rsp_virtual_addr,
  output logic [31:0] rsp_data,
  output logic        imss_busy,
  input  logic        flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic        mem_rsp_error,
  input  logic [31:0] mem_rsp_data,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int LINES   = 1 << INDEX_WIDTH;
  localparam int WORDS   = 1 << OFFSET_WIDTH;
  localparam int LSB_IDX = OFFSET_WIDTH + 2;
  localparam int LSB_TAG = LSB_IDX + INDEX_WIDTH;
  localparam int TAG_W   = 32 - LSB_TAG;

  // state       | meaning
  // IDLE        | lookups accepted, hits/faults answered next cycle
  // REFILL_REQ  | line request held on the backing port until ready
  // REFILL_DATA | collecting refill beats in ascending word order
  // RESPOND     | one-cycle response for the address that missed
  typedef enum logic [1:0] {IDLE, REFILL_REQ, REFILL_DATA, RESPOND} state_t;
  state_t state_q, state_d;

  logic [LINES-1:0]        valid_q, valid_d;
  logic [TAG_W-1:0]        tag_mem [LINES];
  logic [31:0]             data_mem [LINES*WORDS];
  logic [31:0]             addr_q, addr_d;
  logic [OFFSET_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                    err_q, err_d, pend_q, pend_d;
  logic [31:0]             rsp_word_q, rsp_word_d;
  logic                    rsp_valid_q, rsp_valid_d, rsp_illegal_q, rsp_illegal_d;
  logic [31:0]             rsp_addr_q, rsp_addr_d, rsp_data_q, rsp_data_d;

  logic [INDEX_WIDTH-1:0]  req_idx, miss_idx;
  logic [OFFSET_WIDTH-1:0] req_word, miss_word;
  logic [TAG_W-1:0]        req_tag;
  logic accept, misaligned, hit, miss_start, beat, last_beat, fill_ok;

  assign req_word   = req_virtual_addr[LSB_IDX-1:2];
  assign req_idx    = req_virtual_addr[LSB_TAG-1:LSB_IDX];
  assign req_tag    = req_virtual_addr[31:LSB_TAG];
  assign miss_word  = addr_q[LSB_IDX-1:2];
  assign miss_idx   = addr_q[LSB_TAG-1:LSB_IDX];
  assign accept     = (state_q == IDLE) && req_valid;
  assign misaligned = |req_virtual_addr[1:0];
  assign hit        = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign miss_start = accept && !misaligned && !hit;
  assign beat       = (state_q == REFILL_DATA) && mem_rsp_valid;
  assign last_beat  = beat && (beat_cnt_q == '1);
  // A flush on the final beat must also keep the line invalid.
  assign fill_ok    = last_beat && !err_q && !mem_rsp_error && !pend_q && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (miss_start) state_d = REFILL_REQ;
      REFILL_REQ:  if (mem_req_ready) state_d = REFILL_DATA;
      REFILL_DATA: if (last_beat) state_d = RESPOND;
      RESPOND:     state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    imss_busy        = (state_q != IDLE);
    mem_req_valid    = (state_q == REFILL_REQ);
    mem_req_addr     = '0;
    if (mem_req_valid) mem_req_addr = {addr_q[31:LSB_IDX], {LSB_IDX{1'b0}}};
    rsp_valid        = rsp_valid_q;
    rsp_illegal      = rsp_illegal_q;
    rsp_virtual_addr = rsp_addr_q;
    rsp_data         = rsp_data_q;
    if (state_q == RESPOND) begin
      rsp_valid        = 1'b1;
      rsp_illegal      = err_q;
      rsp_virtual_addr = addr_q;
      rsp_data         = err_q ? '0 : rsp_word_q;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (flush)        valid_d = '0;
    else if (fill_ok) valid_d[miss_idx] = 1'b1;
    addr_d     = miss_start ? req_virtual_addr : addr_q;
    beat_cnt_d = miss_start ? '0 : (beat ? beat_cnt_q + 1'b1 : beat_cnt_q);
    err_d      = miss_start ? 1'b0 : (err_q || (beat && mem_rsp_error));
    pend_d     = miss_start ? 1'b0
               : (pend_q || (flush && (state_q == REFILL_REQ || state_q == REFILL_DATA)));
    rsp_word_d    = (beat && beat_cnt_q == miss_word) ? mem_rsp_data : rsp_word_q;
    rsp_valid_d   = accept && (misaligned || hit);
    rsp_illegal_d = accept && misaligned;
    rsp_addr_d    = accept ? req_virtual_addr : rsp_addr_q;
    rsp_data_d    = (accept && !misaligned && hit) ? data_mem[{req_idx, req_word}] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      addr_q        <= '0;
      beat_cnt_q    <= '0;
      err_q         <= 1'b0;
      pend_q        <= 1'b0;
      rsp_word_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rsp_addr_q    <= '0;
      rsp_data_q    <= '0;
    end else begin
      valid_q       <= valid_d;
      addr_q        <= addr_d;
      beat_cnt_q    <= beat_cnt_d;
      err_q         <= err_d;
      pend_q        <= pend_d;
      rsp_word_q    <= rsp_word_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_illegal_q <= rsp_illegal_d;
      rsp_addr_q    <= rsp_addr_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

  // Tag/data arrays are qualified by valid_q, so they carry no reset.
  always_ff @(posedge clk) begin
    if (beat)    data_mem[{miss_idx, beat_cnt_q}] <= mem_rsp_data;
    if (fill_ok) tag_mem[miss_idx] <= addr_q[31:LSB_TAG];
  end

`ifdef LETC_IMSS_PERF_COUNTERS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (accept && !misaligned && hit && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
    if (miss_start && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_letc_core_imss.sv
// Scoreboard bench for letc_core_imss: directed fetches against a scripted backing memory.
module tb_letc_core_imss;

`ifdef LETC_IMSS_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_virtual_addr;
  logic        rsp_valid, rsp_illegal, imss_busy;
  logic [31:0] rsp_virtual_addr, rsp_data;
  logic        flush, flush_stim, flush_mem;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid, mem_rsp_error;
  logic [31:0] mem_rsp_data;
  logic [31:0] hit_count, miss_count;

  assign flush = flush_stim | flush_mem;

  always #5 clk = ~clk;

  letc_core_imss dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_virtual_addr(req_virtual_addr),
    .rsp_valid(rsp_valid), .rsp_illegal(rsp_illegal),
    .rsp_virtual_addr(rsp_virtual_addr), .rsp_data(rsp_data),
    .imss_busy(imss_busy), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_error(mem_rsp_error), .mem_rsp_data(mem_rsp_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        ill;
    logic        busy;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] beat_data [4];
  int          err_beat;
  bit          flush_on_beat;
  bit          mem_enable;
  logic [31:0] exp_mem_addr;
  int          mem_reqs;
  int          reqs_before;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scripted backing memory: ready one cycle after the request shows, then four beats.
  initial begin
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_error = 1'b0;
    mem_rsp_data = '0; flush_mem = 1'b0; mem_reqs = 0;
    forever begin
      @(posedge clk); #1;
      if (mem_req_valid && mem_enable) begin
        mem_reqs++;
        chk("mem_req_addr", mem_req_addr, exp_mem_addr);
        @(posedge clk); #1;
        chk("mem_req_hold", {31'd0, mem_req_valid}, 32'd1);
        chk("mem_req_addr_stable", mem_req_addr, exp_mem_addr);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = beat_data[i];
          mem_rsp_error = (i == err_beat);
          flush_mem     = flush_on_beat && (i == 1);
          @(posedge clk); #1;
        end
        mem_rsp_valid = 1'b0; mem_rsp_error = 1'b0; flush_mem = 1'b0;
      end
    end
  end

  // Monitor: every response strobe pops and checks one expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (sbq.size() == 0) chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
        else begin
          mon_e = sbq.pop_front();
          chk("rsp_addr", rsp_virtual_addr, mon_e.addr);
          chk("rsp_data", rsp_data, mon_e.data);
          chk("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, mon_e.ill});
          chk("rsp_busy", {31'd0, imss_busy}, {31'd0, mon_e.busy});
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input bit is_miss, input bit fl);
    @(posedge clk); #1;
    req_valid = 1'b1; req_virtual_addr = a; flush_stim = fl;
    @(posedge clk); #1;
    req_valid = 1'b0; flush_stim = 1'b0;
    @(negedge clk);
    chk("rsp_latency", {31'd0, rsp_valid}, is_miss ? 32'd0 : 32'd1);
    chk("busy_after_req", {31'd0, imss_busy}, is_miss ? 32'd1 : 32'd0);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!imss_busy) done = 1'b1;
    end
    if (!done) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_miss(input logic [31:0] a, input logic [31:0] b0, input int eb,
                         input bit fob, input logic [31:0] exp_d, input bit exp_ill);
    for (int i = 0; i < 4; i++) beat_data[i] = b0 + i;
    err_beat = eb; flush_on_beat = fob;
    exp_mem_addr = {a[31:4], 4'h0};
    sbq.push_back('{addr: a, data: exp_d, ill: exp_ill, busy: 1'b1});
    issue(a, 1'b1, 1'b0);
    wait_idle();
  endtask

  task automatic do_hit(input logic [31:0] a, input logic [31:0] exp_d, input bit exp_ill, input bit fl);
    reqs_before = mem_reqs;
    sbq.push_back('{addr: a, data: exp_d, ill: exp_ill, busy: 1'b0});
    issue(a, 1'b0, fl);
    repeat (3) @(negedge clk);
    chk("no_mem_access", mem_reqs, reqs_before);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_illegal"}, {31'd0, rsp_illegal}, 32'd0);
    chk({tag, "_rsp_addr"}, rsp_virtual_addr, 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_busy"}, {31'd0, imss_busy}, 32'd0);
    chk({tag, "_mem_req_valid"}, {31'd0, mem_req_valid}, 32'd0);
    chk({tag, "_mem_req_addr"}, mem_req_addr, 32'd0);
    chk({tag, "_hit_count"}, hit_count, 32'd0);
    chk({tag, "_miss_count"}, miss_count, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_virtual_addr = '0; flush_stim = 1'b0;
    err_beat = -1; flush_on_beat = 1'b0; mem_enable = 1'b1; exp_mem_addr = '0;
    for (int i = 0; i < 4; i++) beat_data[i] = '0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1; rst = 1'b0;

    // cold miss, then hit in the same line
    do_miss(32'h0000_1004, 32'hA0, -1, 1'b0, 32'hA1, 1'b0);
    do_hit(32'h0000_100C, 32'hA3, 1'b0, 1'b0);
    chk("hit_count_1", hit_count, PERF ? 32'd1 : 32'd0);
    chk("miss_count_1", miss_count, PERF ? 32'd1 : 32'd0);

    // misaligned fetch faults without touching memory
    do_hit(32'h0000_2002, 32'h0, 1'b1, 1'b0);

    // bus error on beat 2: faulted response, line stays invalid
    do_miss(32'h0000_3000, 32'hB0, 2, 1'b0, 32'h0, 1'b1);
    do_miss(32'h0000_3000, 32'hC0, -1, 1'b0, 32'hC0, 1'b0);
    do_hit(32'h0000_3008, 32'hC2, 1'b0, 1'b0);

    // conflict on index 0
    do_miss(32'h0000_1000, 32'hA0, -1, 1'b0, 32'hA0, 1'b0);
    do_miss(32'h0000_1100, 32'hD0, -1, 1'b0, 32'hD0, 1'b0);
    do_miss(32'h0000_1000, 32'hA0, -1, 1'b0, 32'hA0, 1'b0);

    // flush during refill: response delivered, line not validated
    do_miss(32'h0000_4008, 32'hE0, -1, 1'b1, 32'hE2, 1'b0);
    do_miss(32'h0000_4008, 32'hF0, -1, 1'b0, 32'hF2, 1'b0);
    do_hit(32'h0000_4008, 32'hF2, 1'b0, 1'b0);

    // hit in the flush cycle still returns data; afterwards the line misses
    do_hit(32'h0000_4004, 32'hF1, 1'b0, 1'b1);
    do_miss(32'h0000_4004, 32'h10, -1, 1'b0, 32'h11, 1'b0);
    chk("hit_count_4", hit_count, PERF ? 32'd4 : 32'd0);
    chk("miss_count_9", miss_count, PERF ? 32'd9 : 32'd0);

    // reset while the line request is outstanding
    mem_enable = 1'b0;
    issue(32'h0000_5000, 1'b1, 1'b0);
    chk("refill_req_pending", {31'd0, mem_req_valid}, 32'd1);
    #2 rst = 1'b1;
    #1 chk_outputs_zero("midrefill_reset");
    @(posedge clk); #1; rst = 1'b0; mem_enable = 1'b1;
    do_miss(32'h0000_4004, 32'h20, -1, 1'b0, 32'h21, 1'b0);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
